// File: rtl/timel_counter_if.sv
// CSR-side bundle for timel_counter: access operands and debug halt in, count/tick/carry out.
interface timel_counter_if;
    logic [31:0] d;
    logic        en_rw;
    logic [1:0]  rw_mode;
    logic        halt;
    logic [31:0] qo;
    logic        carry;
    logic        tick;

    modport master (
        output d, en_rw, rw_mode, halt,
        input  qo, carry, tick
    );

    modport slave (
        input  d, en_rw, rw_mode, halt,
        output qo, carry, tick
    );
endinterface

// File: rtl/timel_counter.sv
// Low half of the 64-bit time CSR: prescaled increment, CSR read-modify-write, wrap carry to timeH_reg.
// Define TIMEL_PRESCALER_EN to advance once per DIV cycles; otherwise it advances every non-halted cycle.
module timel_counter #(
    parameter int DIV = 10
) (
    input logic            clk,
    input logic            nreset,
    timel_counter_if.slave bus
);
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    logic [31:0] q_q, q_d;
    logic        carry_q, carry_d;
    logic        tick_q, tick_d;
    logic        wr;
    logic        inc;

    assign wr = bus.en_rw && (bus.rw_mode != 2'b00);

`ifdef TIMEL_PRESCALER_EN
    localparam int PS_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 1);

    logic [PS_W-1:0] ps_q, ps_d;

    assign inc = !bus.halt && (ps_q == PS_LAST);

    // Any write restarts the tick period, so software sees a full DIV cycles before the next step.
    always_comb begin
        ps_d = ps_q;
        if (wr || inc) begin
            ps_d = '0;
        end else if (!bus.halt) begin
            ps_d = ps_q + PS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end
`else
    logic unused_div;
    assign unused_div = (DIV == 0);
    assign inc        = !bus.halt;
`endif

    always_comb begin
        q_d     = q_q;
        carry_d = 1'b0;
        tick_d  = 1'b0;
        if (wr) begin
            // Writes never raise carry, even when the new value is numerically below the old one.
            unique case (bus.rw_mode)
                2'b01:   q_d = bus.d;
                2'b10:   q_d = q_q | bus.d;
                2'b11:   q_d = q_q & ~bus.d;
                default: q_d = q_q;
            endcase
        end else if (inc) begin
            q_d     = q_q + 32'd1;
            tick_d  = 1'b1;
            carry_d = (q_q == ALL_ONES);
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            q_q     <= '0;
            carry_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            q_q     <= q_d;
            carry_q <= carry_d;
            tick_q  <= tick_d;
        end
    end

    assign bus.qo    = q_q;
    assign bus.carry = carry_q;
    assign bus.tick  = tick_q;
endmodule

// File: tb/tb_timel_counter.sv
// Directed bench for timel_counter; expected values are derived from the tick period P.
module tb_timel_counter;
    localparam int DIV_T = 10;
`ifdef TIMEL_PRESCALER_EN
    localparam int P = DIV_T;
`else
    localparam int P = 1;
`endif
    localparam int HP = (P > 7) ? 7 : 0;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    int   nvec = 0;
    int   nerr = 0;

    timel_counter_if bus();

    timel_counter #(.DIV(DIV_T)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.en_rw   = 1'b0;
        bus.rw_mode = 2'b00;
        bus.d       = 32'h0;
    endtask

    task automatic csr_op(input logic [1:0] m, input logic [31:0] v);
        bus.en_rw   = 1'b1;
        bus.rw_mode = m;
        bus.d       = v;
        step();
        idle();
    endtask

    task automatic test_reset();
        idle();
        bus.halt = 1'b0;
        nreset   = 1'b0;
        step();
        step();
        nvec++; if (bus.qo !== 32'h0) begin nerr++; $display("FAIL reset_qo got=%h exp=%h", bus.qo, 32'h0); end
        nvec++; if (bus.tick !== 1'b0) begin nerr++; $display("FAIL reset_tick got=%b exp=0", bus.tick); end
        nvec++; if (bus.carry !== 1'b0) begin nerr++; $display("FAIL reset_carry got=%b exp=0", bus.carry); end
        nreset = 1'b1;
    endtask

    task automatic test_count();
        logic [31:0] eq;
        logic        et;
        for (int k = 1; k <= 2 * P + 5; k++) begin
            step();
            eq = 32'(k / P);
            et = ((k % P) == 0);
            nvec++; if (bus.qo !== eq) begin nerr++; $display("FAIL count_qo k=%0d got=%h exp=%h", k, bus.qo, eq); end
            nvec++; if (bus.tick !== et) begin nerr++; $display("FAIL count_tick k=%0d got=%b exp=%b", k, bus.tick, et); end
            nvec++; if (bus.carry !== 1'b0) begin nerr++; $display("FAIL count_carry k=%0d got=%b exp=0", k, bus.carry); end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] eq;
        logic        ec;
        logic        et;
        csr_op(2'b01, 32'hFFFF_FFFE);
        nvec++; if (bus.qo !== 32'hFFFF_FFFE) begin nerr++; $display("FAIL wrap_write got=%h exp=%h", bus.qo, 32'hFFFF_FFFE); end
        nvec++; if (bus.tick !== 1'b0) begin nerr++; $display("FAIL wrap_write_tick got=%b exp=0", bus.tick); end
        for (int k = 1; k <= 2 * P + 1; k++) begin
            step();
            eq = 32'hFFFF_FFFE + 32'(k / P);
            ec = (k == 2 * P);
            et = ((k % P) == 0);
            nvec++; if (bus.qo !== eq) begin nerr++; $display("FAIL wrap_qo k=%0d got=%h exp=%h", k, bus.qo, eq); end
            nvec++; if (bus.carry !== ec) begin nerr++; $display("FAIL wrap_carry k=%0d got=%b exp=%b", k, bus.carry, ec); end
            nvec++; if (bus.tick !== et) begin nerr++; $display("FAIL wrap_tick k=%0d got=%b exp=%b", k, bus.tick, et); end
        end
    endtask

    task automatic test_set_clear();
        logic [31:0] eq;
        logic        et;
        bus.en_rw = 1'b1; bus.rw_mode = 2'b01; bus.d = 32'h100;
        step();
        nvec++; if (bus.qo !== 32'h100) begin nerr++; $display("FAIL rw_qo got=%h exp=%h", bus.qo, 32'h100); end
        bus.rw_mode = 2'b10; bus.d = 32'h0F0;
        step();
        nvec++; if (bus.qo !== 32'h1F0) begin nerr++; $display("FAIL rs_qo got=%h exp=%h", bus.qo, 32'h1F0); end
        bus.rw_mode = 2'b11; bus.d = 32'h030;
        step();
        idle();
        nvec++; if (bus.qo !== 32'h1C0) begin nerr++; $display("FAIL rc_qo got=%h exp=%h", bus.qo, 32'h1C0); end
        nvec++; if (bus.tick !== 1'b0) begin nerr++; $display("FAIL rc_tick got=%b exp=0", bus.tick); end
        for (int k = 1; k <= P; k++) begin
            step();
            eq = (k == P) ? 32'h1C1 : 32'h1C0;
            et = (k == P);
            nvec++; if (bus.qo !== eq) begin nerr++; $display("FAIL rc_period_qo k=%0d got=%h exp=%h", k, bus.qo, eq); end
            nvec++; if (bus.tick !== et) begin nerr++; $display("FAIL rc_period_tick k=%0d got=%b exp=%b", k, bus.tick, et); end
        end
    endtask

    task automatic test_read();
        csr_op(2'b01, 32'h5);
        repeat (P - 1) step();
        nvec++; if (bus.qo !== 32'h5) begin nerr++; $display("FAIL read_pre got=%h exp=%h", bus.qo, 32'h5); end
        csr_op(2'b00, 32'hFFFF);
        nvec++; if (bus.qo !== 32'h6) begin nerr++; $display("FAIL read_inc_qo got=%h exp=%h", bus.qo, 32'h6); end
        nvec++; if (bus.tick !== 1'b1) begin nerr++; $display("FAIL read_inc_tick got=%b exp=1", bus.tick); end
    endtask

    task automatic test_write_vs_inc();
        csr_op(2'b01, 32'hFFFF_FFFF);
        repeat (P - 1) step();
        csr_op(2'b01, 32'hFFFF_FFFF);
        nvec++; if (bus.qo !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL wvi_qo got=%h exp=%h", bus.qo, 32'hFFFF_FFFF); end
        nvec++; if (bus.carry !== 1'b0) begin nerr++; $display("FAIL wvi_carry got=%b exp=0", bus.carry); end
        nvec++; if (bus.tick !== 1'b0) begin nerr++; $display("FAIL wvi_tick got=%b exp=0", bus.tick); end
    endtask

    task automatic test_halt();
        logic [31:0] eq;
        logic        et;
        csr_op(2'b01, 32'h20);
        repeat (HP) step();
        bus.halt = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            step();
            nvec++; if (bus.qo !== 32'h20) begin nerr++; $display("FAIL halt_qo k=%0d got=%h exp=%h", k, bus.qo, 32'h20); end
            nvec++; if (bus.tick !== 1'b0) begin nerr++; $display("FAIL halt_tick k=%0d got=%b exp=0", k, bus.tick); end
            nvec++; if (bus.carry !== 1'b0) begin nerr++; $display("FAIL halt_carry k=%0d got=%b exp=0", k, bus.carry); end
        end
        bus.halt = 1'b0;
        for (int k = 1; k <= P - HP; k++) begin
            step();
            eq = (k == P - HP) ? 32'h21 : 32'h20;
            et = (k == P - HP);
            nvec++; if (bus.qo !== eq) begin nerr++; $display("FAIL resume_qo k=%0d got=%h exp=%h", k, bus.qo, eq); end
            nvec++; if (bus.tick !== et) begin nerr++; $display("FAIL resume_tick k=%0d got=%b exp=%b", k, bus.tick, et); end
        end
    endtask

    task automatic test_reset_mid();
        csr_op(2'b01, 32'h1234);
        nvec++; if (bus.qo !== 32'h1234) begin nerr++; $display("FAIL rmid_pre got=%h exp=%h", bus.qo, 32'h1234); end
        nreset = 1'b0;
        step();
        nvec++; if (bus.qo !== 32'h0) begin nerr++; $display("FAIL rmid_qo got=%h exp=0", bus.qo); end
        nreset = 1'b1;
        csr_op(2'b01, 32'hFFFF_FFFF);
        repeat (P - 1) step();
        nreset = 1'b0;
        step();
        nvec++; if (bus.qo !== 32'h0) begin nerr++; $display("FAIL rwrap_qo got=%h exp=0", bus.qo); end
        nvec++; if (bus.carry !== 1'b0) begin nerr++; $display("FAIL rwrap_carry got=%b exp=0", bus.carry); end
        nvec++; if (bus.tick !== 1'b0) begin nerr++; $display("FAIL rwrap_tick got=%b exp=0", bus.tick); end
        nreset = 1'b1;
        for (int k = 1; k <= 3 * P; k++) begin
            step();
            nvec++; if (bus.qo !== 32'(k / P)) begin nerr++; $display("FAIL post_reset_qo k=%0d got=%h exp=%h", k, bus.qo, 32'(k / P)); end
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_wrap();
        test_set_clear();
        test_read();
        test_write_vs_inc();
        test_halt();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/timel_counter.md
# timel_counter

Low 32-bit half of the 64-bit `time` CSR. Increments on a prescaled tick, accepts CSR read-modify-write updates, and generates the one-cycle `carry` pulse that the downstream high-half register (`timeH_reg`) consumes to advance the upper 32 bits. It sits in the CSR unit between the core clock and the high-half register.

## Interface

Parameters:
- `DIV`, default 10: core-clock cycles per time tick. Legal range 1..65536; prescaler width is `$clog2(DIV)`, minimum 1 bit.

Ports:
- `clk`  in  1  core clock; all logic is rising-edge.
- `nreset`  in  1  reset, synchronous, active-low.
- `d`  in  32  CSR write operand.
- `en_rw`  in  1  CSR access strobe for this register, one cycle per access.
- `rw_mode`  in  2  CSR op: 00 read-only, 01 CSRRW, 10 CSRRS, 11 CSRRC.
- `halt`  in  1  debug freeze. While high, the counter and prescaler hold.
- `qo`  out  32  current low count, registered.
- `carry`  out  1  one-cycle pulse on wrap 0xFFFFFFFF -> 0x00000000, registered.
- `tick`  out  1  one-cycle strobe on each counter increment, registered.

## Operation

- State: `q[31:0]`, prescaler `ps`, registered `carry`, registered `tick`.
- Reset (`nreset` low at a rising edge): `q`=0, `ps`=0, `carry`=0, `tick`=0. Reset overrides every other input. `qo`=0 from the first edge with `nreset` low.
- Internal increment enable `inc` = !`halt` && (`ps` == DIV-1).
- Priority per edge, highest first:
  - reset;
  - CSR write;
  - increment;
  - hold.
- CSR write occurs when `en_rw` && `rw_mode` != 00:
  - 01: `q` <= `d`.
  - 10: `q` <= `q` | `d`.
  - 11: `q` <= `q` & ~`d`.
  - `ps` <= 0, `carry` <= 0, `tick` <= 0.
  - A write in an `inc` cycle discards that increment. No carry is produced by a write, even if `d` causes a numeric wrap.
- `en_rw` with `rw_mode` 00 is a read. State is unchanged; `qo` is already valid.
- Increment (no write, `inc`=1):
  - `q` <= `q`+1, modulo 2^32.
  - `ps` <= 0.
  - `tick` <= 1.
  - `carry` <= (`q` == 32'hFFFFFFFF).
- Otherwise:
  - if !`halt`, `ps` <= `ps`+1;
  - `q` holds;
  - `carry` <= 0, `tick` <= 0.
- `halt` high: `ps` and `q` hold, and `carry`/`tick` are forced 0 on the next edge. Deasserting `halt` resumes from the held `ps`.

## Timing

- `qo` = `q` directly, with zero combinational logic on the output.
- Increment: the edge where `inc`=1 updates `q`. `qo` shows the new value in the following cycle.
- `tick` and `carry` are high in that same following cycle, for exactly one cycle.
- `carry` is coincident with `qo` == 0. The high half samples it on the next edge, so the 64-bit value is momentarily {H, 0} for one cycle before H advances.
- Write latency: `qo` reflects the write result one cycle after the `en_rw` edge.
- Increment period is exactly DIV cycles of non-halted time. Back-to-back `carry` pulses are impossible: the minimum spacing is 2^32·DIV cycles.
- Read-during-increment: a read sampling `qo` in the `inc` cycle returns the pre-increment value.

## Configuration

- `TIMEL_PRESCALER_EN` defined: behaviour as above, with `DIV` honoured.
- Not defined:
  - the prescaler is removed and `inc` = !`halt`, so the counter advances every non-halted cycle;
  - `DIV` is ignored;
  - `tick` is high in every cycle following a non-halted, non-write edge.
  - All other rules, including write priority and carry, are unchanged.

## Test plan

- Reset, then 25 cycles with DIV=10 and macro on. Require `qo`=0,0,…: it becomes 1 after cycle 10 and 2 after cycle 20. `tick` pulses once per 10 cycles, and `carry` stays 0.
- CSRRW `d`=32'hFFFFFFFE, then let it run. Require `qo` to step FFFFFFFE -> FFFFFFFF -> 00000000. `carry`=1 only in the cycle where `qo`=0, and 0 before and after.
- CSRRS `d`=0x0F0 on `q`=0x100, then CSRRC `d`=0x030. Require `qo`=0x1F0, then 0x1C0. Both writes reset `ps`, so the next increment comes DIV cycles after the second write.
- CSRRW `d`=32'hFFFFFFFF issued in the exact cycle where `inc`=1 and `q`=32'hFFFFFFFF. Require `qo`=FFFFFFFF and `carry`=0 (write wins, no wrap).
- Assert `halt` when `ps`=7, hold it for 50 cycles, then release. Require `qo` and `ps` frozen, with `tick`/`carry` at 0 throughout. The increment then occurs 3 cycles after release.
- `nreset` low mid-count with `qo`=0x1234 and `carry` pending. Require `qo`=0, `carry`=0 and `tick`=0 on the next edge. With the macro undefined, require `qo` to increment every cycle after reset.
